// File: rtl/alu_b_operand_stage.sv
// alu_b_operand_stage: ID/EX operand-B select with rt forwarding, immediate extension, stall and flush
module alu_b_operand_stage #(
  parameter int WIDTH = 32,
  parameter int RA_W  = 5,
  parameter int IMM_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [RA_W-1:0]  rt_addr,
  input  logic [WIDTH-1:0] rt_data,
  input  logic [IMM_W-1:0] imm,
  input  logic [1:0]       ext_op,
  input  logic             b_sel,
  input  logic             mem_we,
  input  logic [RA_W-1:0]  mem_wa,
  input  logic [WIDTH-1:0] mem_wd,
  input  logic             wb_we,
  input  logic [RA_W-1:0]  wb_wa,
  input  logic [WIDTH-1:0] wb_wd,
  output logic [WIDTH-1:0] ex_b,
  output logic [WIDTH-1:0] ex_rt,
  output logic             ex_valid,
  output logic [1:0]       ex_fwd
);
  logic [WIDTH-1:0] fwd_rt, ext_imm, sel_b, ex_b_d, ex_b_q, ex_rt_d, ex_rt_q;
  logic [1:0] src, ex_fwd_d, ex_fwd_q;
  logic mem_hit, wb_hit, ex_valid_d, ex_valid_q;
  always_comb begin
    mem_hit = mem_we && mem_wa == rt_addr && rt_addr != '0;
    wb_hit = wb_we && wb_wa == rt_addr && rt_addr != '0;
    fwd_rt = mem_hit ? mem_wd : wb_hit ? wb_wd : rt_data;
    src = mem_hit ? 2'd1 : wb_hit ? 2'd2 : 2'd0;
    ext_imm = ext_op == 2'd0 ? WIDTH'(imm) :
              ext_op == 2'd1 ? {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm} :
              ext_op == 2'd2 ? WIDTH'({imm, {IMM_W{1'b0}}}) : WIDTH'(imm[10:6]);
    sel_b = b_sel ? ext_imm : fwd_rt;
    ex_b_d = flush ? '0 : stall ? ex_b_q : sel_b;
    ex_rt_d = flush ? '0 : stall ? ex_rt_q : fwd_rt;
    ex_valid_d = flush ? 1'b0 : stall ? ex_valid_q : in_valid;
    ex_fwd_d = flush ? 2'd0 : stall ? ex_fwd_q : b_sel ? 2'd0 : src;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_b_q <= '0;
      ex_rt_q <= '0;
      ex_valid_q <= 1'b0;
      ex_fwd_q <= 2'd0;
    end else begin
      ex_b_q <= ex_b_d;
      ex_rt_q <= ex_rt_d;
      ex_valid_q <= ex_valid_d;
      ex_fwd_q <= ex_fwd_d;
    end
  end
  assign ex_b = ex_b_q;
  assign ex_rt = ex_rt_q;
  assign ex_valid = ex_valid_q;
  assign ex_fwd = ex_fwd_q;
endmodule

// File: doc/alu_b_operand_stage.md
Name: alu_b_operand_stage

Overview:
- Parametrised next generation of the ALU operand-B selector for the pipelined MIPS core.
- Sits at the ID/EX boundary. It resolves operand B from one of three sources:
  - register rt, with MEM→ID and WB→ID forwarding;
  - a 16-bit immediate, via one of four extension modes;
  - the shift amount.
- The chosen operand, the forwarded rt value (for stores) and a valid bit are registered into the EX stage.
- Honours pipeline stall (hold) and flush (bubble).

Parameters:
- WIDTH, 32, datapath width; legal range WIDTH ≥ 2*IMM_W.
- RA_W, 5, register address width.
- IMM_W, 16, raw immediate width.

Ports:
- clk  input  1  pipeline clock, rising edge
- reset  input  1  synchronous, active-high; clears every output register
- stall  input  1  hold all output registers this cycle
- flush  input  1  load a bubble (all outputs 0) this cycle
- in_valid  input  1  ID-stage instruction valid
- rt_addr  input  RA_W  source register number of rt
- rt_data  input  WIDTH  GRF read value of rt
- imm  input  IMM_W  raw immediate field
- ext_op  input  2  immediate mode: 0 zero-ext, 1 sign-ext, 2 upper (lui), 3 shamt
- b_sel  input  1  0 = forwarded rt, 1 = extended immediate
- mem_we  input  1  MEM-stage register write enable
- mem_wa  input  RA_W  MEM-stage destination register
- mem_wd  input  WIDTH  MEM-stage write data
- wb_we  input  1  WB-stage register write enable
- wb_wa  input  RA_W  WB-stage destination register
- wb_wd  input  WIDTH  WB-stage write data
- ex_b  output  WIDTH  registered ALU operand B
- ex_rt  output  WIDTH  registered forwarded rt value (store data)
- ex_valid  output  1  registered instruction valid
- ex_fwd  output  2  registered forward source: 0 none, 1 MEM, 2 WB

Behaviour:
- One clock; reset is synchronous and active-high, on clk.
- Reset values: ex_b=0, ex_rt=0, ex_valid=0, ex_fwd=0.

Forwarding (combinational, ID side):
- If mem_we && mem_wa==rt_addr && rt_addr!=0: fwd_rt=mem_wd, src=1.
- Else if wb_we && wb_wa==rt_addr && rt_addr!=0: fwd_rt=wb_wd, src=2.
- Else: fwd_rt=rt_data, src=0.
- MEM has priority over WB when both match.
- Register 0 is never forwarded, regardless of the enables.

Immediate extension (combinational), result is WIDTH bits:
- ext_op=0: upper WIDTH-IMM_W bits are zero.
- ext_op=1: imm[IMM_W-1] is replicated into the upper bits.
- ext_op=2: imm is placed at bits [2*IMM_W-1:IMM_W]; all other bits are zero.
- ext_op=3: imm[10:6] is zero-extended (shamt field).

Selection:
- sel_b = b_sel ? ext_imm : fwd_rt.
- ex_rt always captures fwd_rt, independent of b_sel.
- ex_fwd captures src only when b_sel=0; otherwise it captures 0.

Register update, evaluated at each rising clk edge in strict priority order:
1. reset → all outputs 0.
2. flush → all outputs 0 (bubble). Flush wins over a simultaneous stall.
3. stall → all outputs hold their previous values. Forwarding inputs changing during the stall have no effect.
4. Otherwise → ex_b=sel_b, ex_rt=fwd_rt, ex_valid=in_valid, ex_fwd as above.

Timing:
- Latency is exactly 1 cycle from ID inputs to ex_* outputs.
- No combinational path from any input to any output.

Boundary conditions:
- Reset asserted mid-stall clears the outputs.
- After deassertion of reset, the first edge loads normally.
- in_valid=0 still loads data. ex_valid=0 marks the bubble; downstream ignores ex_b.
- Sign-extension for ext_op=1 is correct for any legal WIDTH, not only 32.

Test Plan:
1. Reset, then rt_addr=3, rt_data=0x11111111, mem_we=1, mem_wa=3, mem_wd=0xAAAA0000, wb_we=1, wb_wa=3, wb_wd=0xBBBB0000, b_sel=0 → next cycle ex_b=ex_rt=0xAAAA0000, ex_fwd=1. Then mem_we=0 → ex_b=0xBBBB0000, ex_fwd=2.
2. rt_addr=0, mem_we=1, mem_wa=0, mem_wd=0xDEADBEEF, rt_data=0 → ex_b=0, ex_fwd=0 (no forward of $0).
3. imm=0x8001, b_sel=1, stepping ext_op=0,1,2,3 on consecutive cycles → ex_b sequence 0x00008001, 0xFFFF8001, 0x80010000, 0x00000000 (imm[10:6]=0). Then imm=0x07C0, ext_op=3 → 0x0000001F.
4. Load ex_b=0x12345678, then stall=1 for 3 cycles while rt_data, mem_wd and imm change → ex_b, ex_rt, ex_valid, ex_fwd are unchanged for all 3 cycles. Release stall → new values appear 1 cycle later.
5. stall=1 and flush=1 on the same edge with ex_valid=1 → ex_valid=0, ex_b=0, ex_rt=0, ex_fwd=0.
6. Assert reset during a stall with ex_b=0x12345678 → outputs are 0 on that edge. Deassert reset with in_valid=1, rt_data=5 → ex_b=5, ex_valid=1 on the following edge.
7. Rerun scenarios 1 and 3 with WIDTH=48 → ext_op=1, imm=0x8001 gives 0xFFFFFFFF8001, and forwarding results match at full width.
